key_search_scheduler: RTL and testbench
=======================================

Name: key_search_scheduler

Overview:
- Dispatches 22-bit RC4 key candidates to NUM_CORES parallel decryption cores and collects their pass/fail results.
- Stops on the first correct key, or reports exhaustion when the whole key space fails.
- Sits between the top-level control (switches/buttons, HEX display) and the replicated decrypt cores. It replaces per-core key counters with one shared, ordered key source.

Parameters:
- NUM_CORES, 4, number of decryption cores served (1..16)
- KEY_WIDTH, 22, candidate key width; key space is 0 .. 2^KEY_WIDTH-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a search from key 0 (ignored unless IDLE, FOUND or EXHAUSTED)
- core_start  out  NUM_CORES  one-cycle pulse per core: latch core_key and begin a trial
- core_key  out  NUM_CORES*KEY_WIDTH  per-core candidate; slice i = bits [i*KEY_WIDTH +: KEY_WIDTH], held until that core's next dispatch
- core_done  in  NUM_CORES  one-cycle pulse per core: trial finished
- core_match  in  NUM_CORES  valid only with core_done; 1 = key decrypted correctly
- busy  out  1  high in DISPATCH and DRAIN
- found  out  1  high in FOUND
- exhausted  out  1  high in EXHAUSTED
- found_key  out  KEY_WIDTH  matching key; valid while found
- keys_tried  out  KEY_WIDTH+1  count of trials completed in the current search

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All of the following are 0: core_start, core_key, busy, found, exhausted, found_key, keys_tried, next_key, the core_busy vector and the space_done flag.
- States: IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED.
- Transitions:
  - IDLE/FOUND/EXHAUSTED + start -> DISPATCH. On this transition: clear next_key, core_busy, space_done, keys_tried, found_key.
  - DISPATCH + any accepted match -> DRAIN.
  - DISPATCH + space_done + all cores idle (after this cycle's completions) -> EXHAUSTED.
  - DRAIN + all cores idle -> FOUND.
  - FOUND and EXHAUSTED hold until start.
- Dispatch, in DISPATCH only:
  - At most one core per cycle: the lowest-index core whose registered core_busy bit is 0, if space_done=0.
  - That cycle: core_start[i]=1, core_key slice i = next_key, core_busy[i] set, next_key increments.
  - Keys are issued strictly ascending from 0.
  - Dispatching next_key = 2^KEY_WIDTH-1 sets space_done. next_key does not wrap into a reissue.
- Completion:
  - core_done[i] clears core_busy[i] at the clock edge. That core is eligible for dispatch the following cycle, not the same cycle.
  - core_done for a core that is not busy is ignored: no count, no match.
  - keys_tried increments by popcount(core_done & core_busy) per cycle, in DISPATCH and DRAIN.
- Match:
  - In DISPATCH, the lowest-index core with core_done & core_match & core_busy wins. Its key is latched into found_key.
  - Simultaneous matches: lowest index wins; the others are counted but ignored.
  - Matches arriving in DRAIN are counted but do not overwrite found_key.
  - A match on the same cycle the space finishes -> DRAIN, never EXHAUSTED.
- DRAIN: no dispatch. Waits for every busy core's core_done so cores are idle before the next search.
- start while busy (DISPATCH/DRAIN): ignored.
- reset_n low mid-search: immediate return to reset values. The cores are reset by the same reset_n.
- Outputs busy/found/exhausted are decoded from the registered state. core_start is registered.
- Latency: start -> first core_start = 1 cycle. Last core_done -> found/exhausted = 1 cycle.

Test Plan:
- NUM_CORES=4, cores respond 10 cycles after core_start, no matches, start pulse -> core_start[0..3] on cycles 1..4 with keys 0,1,2,3; key 4 goes to core 0 on the cycle after its done.
- Match on the core holding key 0x00002A, while two other cores are in flight -> DRAIN until both done, then found=1, found_key=0x00002A, busy=0.
- core_done with core_match on cores 1 and 3 in the same cycle (keys 5 and 7) -> found_key=5, keys_tried includes both.
- KEY_WIDTH=4, no matches -> exactly 16 dispatches (keys 0..15, none repeated), exhausted=1, keys_tried=16.
- KEY_WIDTH=4, match on key 15 in the final completion cycle -> found=1, found_key=15, exhausted stays 0.
- Assert reset_n low mid-DISPATCH -> all outputs 0 asynchronously. Then start -> dispatch restarts at key 0. A start pulse during DRAIN has no effect.

Source files
------------

// File: rtl/key_search_if.sv
// Handshake bundle between the key search scheduler, the top-level control
// and the replicated decrypt cores.
interface key_search_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 22
);
  logic                           start;
  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_match;
  logic                           busy;
  logic                           found;
  logic                           exhausted;
  logic [KEY_WIDTH-1:0]           found_key;
  logic [KEY_WIDTH:0]             keys_tried;

  modport master (
    input  start, core_done, core_match,
    output core_start, core_key, busy, found, exhausted, found_key, keys_tried
  );

  modport slave (
    output start, core_done, core_match,
    input  core_start, core_key, busy, found, exhausted, found_key, keys_tried
  );
endinterface

// File: rtl/key_search_scheduler.sv
// Shared ordered key source for NUM_CORES RC4 decrypt cores: issues keys in
// ascending order, collects pass/fail results and stops on the first match.
module key_search_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 22
) (
  input  logic         clk,
  input  logic         reset_n,
  key_search_if.master bus
);

  typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED} state_t;

  localparam logic [KEY_WIDTH-1:0] KEY_MAX = '1;

  state_t                         state, state_nxt;
  logic [KEY_WIDTH-1:0]           next_key;
  logic [NUM_CORES-1:0]           core_busy;
  logic                           space_done;
  logic [NUM_CORES-1:0]           core_start_r;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_r;
  logic [KEY_WIDTH-1:0]           found_key_r;
  logic [KEY_WIDTH:0]             keys_tried_r;

  logic [NUM_CORES-1:0] done_valid;
  logic [NUM_CORES-1:0] match_sel;
  logic                 match_any;
  logic [NUM_CORES-1:0] dispatch_sel;
  logic [NUM_CORES-1:0] busy_after;
  logic [KEY_WIDTH-1:0] match_key;
  logic                 restart;

  function automatic logic [NUM_CORES-1:0] lowest_onehot(input logic [NUM_CORES-1:0] v);
    logic [NUM_CORES-1:0] r;
    logic                 hit;
    r   = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (v[i] && !hit) begin
        r[i] = 1'b1;
        hit  = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [KEY_WIDTH:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [KEY_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) n = n + (KEY_WIDTH+1)'(v[i]);
    return n;
  endfunction

  // Completions from idle cores are spurious and never count or match.
  assign done_valid = bus.core_done & core_busy;
  assign match_sel  = lowest_onehot(done_valid & bus.core_match);
  assign match_any  = |match_sel;
  assign busy_after = core_busy & ~done_valid;
  assign restart    = bus.start && (state == IDLE || state == FOUND || state == EXHAUSTED);

  // A winning match stops issuing immediately so only cores already in flight drain.
  assign dispatch_sel = (state == DISPATCH && !space_done && !match_any)
                        ? lowest_onehot(~core_busy) : '0;

  always_comb begin
    match_key = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (match_sel[i]) match_key = core_key_r[i*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FOUND, EXHAUSTED: if (bus.start) state_nxt = DISPATCH;
      DISPATCH: begin
        if (match_any)                             state_nxt = DRAIN;
        else if (space_done && busy_after == '0)   state_nxt = EXHAUSTED;
      end
      DRAIN:    if (busy_after == '0) state_nxt = FOUND;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_key     <= '0;
      core_busy    <= '0;
      space_done   <= 1'b0;
      core_start_r <= '0;
      core_key_r   <= '0;
      found_key_r  <= '0;
      keys_tried_r <= '0;
    end else begin
      core_start_r <= dispatch_sel;
      if (restart) begin
        next_key     <= '0;
        core_busy    <= '0;
        space_done   <= 1'b0;
        keys_tried_r <= '0;
        found_key_r  <= '0;
      end else begin
        core_busy <= busy_after | dispatch_sel;
        if (state == DISPATCH || state == DRAIN)
          keys_tried_r <= keys_tried_r + popcount(done_valid);
        // The top key marks the space as issued instead of wrapping back to 0.
        if (|dispatch_sel) begin
          if (next_key == KEY_MAX) space_done <= 1'b1;
          else                     next_key   <= next_key + 1'b1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
          if (dispatch_sel[i]) core_key_r[i*KEY_WIDTH +: KEY_WIDTH] <= next_key;
        end
        if (state == DISPATCH && match_any) found_key_r <= match_key;
      end
    end
  end

  assign bus.core_start = core_start_r;
  assign bus.core_key   = core_key_r;
  assign bus.busy       = (state == DISPATCH) || (state == DRAIN);
  assign bus.found      = (state == FOUND);
  assign bus.exhausted  = (state == EXHAUSTED);
  assign bus.found_key  = found_key_r;
  assign bus.keys_tried = keys_tried_r;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler: a 22-bit instance for ordering and
// match scenarios and a 4-bit instance for whole-space exhaustion.
module tb_key_search_scheduler;
  localparam int NC  = 4;
  localparam int KWA = 22;
  localparam int KWB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_search_if #(.NUM_CORES(NC), .KEY_WIDTH(KWA)) ifa();
  key_search_if #(.NUM_CORES(NC), .KEY_WIDTH(KWB)) ifb();

  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KWA)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.master));
  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KWB)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.master));

  int checks   = 0;
  int failures = 0;

  // Core models: done pulses lat[i] cycles after core_start, match on a target key.
  int             cnt_a[NC];
  int             lat_a[NC];
  logic [KWA-1:0] key_a[NC];
  logic [KWA-1:0] tgt_a0, tgt_a1;
  bit             tgt_a_en;
  int             cnt_b[NC];
  int             lat_b[NC];
  logic [KWB-1:0] key_b[NC];
  logic [KWB-1:0] tgt_b;
  bit             tgt_b_en;

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      ifa.core_done[i]  = 1'b0;
      ifa.core_match[i] = 1'b0;
      if (!reset_n) cnt_a[i] = 0;
      else begin
        if (cnt_a[i] > 0) begin
          cnt_a[i]--;
          if (cnt_a[i] == 0) begin
            ifa.core_done[i]  = 1'b1;
            ifa.core_match[i] = tgt_a_en && (key_a[i] == tgt_a0 || key_a[i] == tgt_a1);
          end
        end
        if (ifa.core_start[i]) begin
          key_a[i] = ifa.core_key[i*KWA +: KWA];
          cnt_a[i] = lat_a[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      ifb.core_done[i]  = 1'b0;
      ifb.core_match[i] = 1'b0;
      if (!reset_n) cnt_b[i] = 0;
      else begin
        if (cnt_b[i] > 0) begin
          cnt_b[i]--;
          if (cnt_b[i] == 0) begin
            ifb.core_done[i]  = 1'b1;
            ifb.core_match[i] = tgt_b_en && (key_b[i] == tgt_b);
          end
        end
        if (ifb.core_start[i]) begin
          key_b[i] = ifb.core_key[i*KWB +: KWB];
          cnt_b[i] = lat_b[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic pulse_start_b();
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", ifa.busy); end
    checks++; if (ifa.found !== 1'b0) begin failures++; $display("FAIL reset_found: got %0d expected 0", ifa.found); end
    checks++; if (ifa.exhausted !== 1'b0) begin failures++; $display("FAIL reset_exhausted: got %0d expected 0", ifa.exhausted); end
    checks++; if (ifa.core_start !== 4'b0) begin failures++; $display("FAIL reset_core_start: got %b expected 0000", ifa.core_start); end
    checks++; if (ifa.core_key !== '0) begin failures++; $display("FAIL reset_core_key: got %h expected 0", ifa.core_key); end
    checks++; if (ifa.keys_tried !== 23'd0) begin failures++; $display("FAIL reset_keys_tried: got %0d expected 0", ifa.keys_tried); end
    checks++; if (ifa.found_key !== 22'd0) begin failures++; $display("FAIL reset_found_key: got %h expected 0", ifa.found_key); end
    reset_n = 1'b1;
    tick();
    checks++; if (ifb.busy !== 1'b0 || ifb.exhausted !== 1'b0) begin failures++; $display("FAIL reset_b_idle: got busy=%0d exh=%0d expected 0 0", ifb.busy, ifb.exhausted); end
  endtask

  task automatic test_dispatch_order();
    logic [NC-1:0] exp_cs;
    int idx, ek;
    for (int i = 0; i < NC; i++) lat_a[i] = 10;
    tgt_a_en = 1'b0;
    pulse_start_a();
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k <= 4)       begin exp_cs = 4'(1 << (k-1)); idx = k-1;  ek = k-1; end
      else if (k == 13) begin exp_cs = 4'b0001;        idx = 0;    ek = 4;   end
      else if (k == 14) begin exp_cs = 4'b0010;        idx = 1;    ek = 5;   end
      else              begin exp_cs = 4'b0000;        idx = 0;    ek = 0;   end
      checks++;
      if (ifa.core_start !== exp_cs) begin
        failures++; $display("FAIL order_core_start cycle %0d: got %b expected %b", k, ifa.core_start, exp_cs);
      end
      if (exp_cs != 4'b0000) begin
        checks++;
        if (ifa.core_key[idx*KWA +: KWA] !== KWA'(ek)) begin
          failures++; $display("FAIL order_core_key cycle %0d core %0d: got %0d expected %0d", k, idx, ifa.core_key[idx*KWA +: KWA], ek);
        end
      end
    end
    checks++; if (ifa.keys_tried !== 23'd3) begin failures++; $display("FAIL order_keys_tried: got %0d expected 3", ifa.keys_tried); end
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL order_busy: got %0d expected 1", ifa.busy); end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    #1;
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %0d expected 0", ifa.busy); end
    checks++; if (ifa.core_key !== '0) begin failures++; $display("FAIL midreset_core_key: got %h expected 0", ifa.core_key); end
    checks++; if (ifa.keys_tried !== 23'd0) begin failures++; $display("FAIL midreset_keys_tried: got %0d expected 0", ifa.keys_tried); end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start_a();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (ifa.core_start !== 4'(1 << (k-1)) || ifa.core_key[(k-1)*KWA +: KWA] !== KWA'(k-1)) begin
        failures++; $display("FAIL restart_dispatch cycle %0d: got start=%b key=%0d expected start=%b key=%0d",
                             k, ifa.core_start, ifa.core_key[(k-1)*KWA +: KWA], 4'(1 << (k-1)), k-1);
      end
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_match_drain();
    int m, f;
    for (int i = 0; i < NC; i++) lat_a[i] = 10;
    tgt_a0 = 22'h00002A; tgt_a1 = 22'h00002A; tgt_a_en = 1'b1;
    m = -1; f = -1;
    pulse_start_a();
    for (int k = 1; k <= 400; k++) begin
      tick();
      ifa.start = 1'b0;
      if (m < 0 && (ifa.core_done & ifa.core_match) != 4'b0) begin
        m = k;
        checks++;
        if (ifa.busy !== 1'b1 || ifa.found !== 1'b0 || ifa.keys_tried !== 23'd43) begin
          failures++; $display("FAIL drain_entry: got busy=%0d found=%0d tried=%0d expected 1 0 43", ifa.busy, ifa.found, ifa.keys_tried);
        end
        ifa.start = 1'b1;
      end
      if (ifa.found) begin f = k; break; end
    end
    ifa.start = 1'b0;
    checks++; if (m != 134) begin failures++; $display("FAIL match_cycle: got %0d expected 134", m); end
    checks++; if (f - m != 10) begin failures++; $display("FAIL drain_length: got %0d expected 10 (found at %0d)", f - m, f); end
    checks++; if (ifa.found_key !== 22'h00002A) begin failures++; $display("FAIL drain_found_key: got %h expected 00002a", ifa.found_key); end
    checks++; if (ifa.busy !== 1'b0 || ifa.exhausted !== 1'b0) begin failures++; $display("FAIL drain_flags: got busy=%0d exh=%0d expected 0 0", ifa.busy, ifa.exhausted); end
    checks++; if (ifa.keys_tried !== 23'd45) begin failures++; $display("FAIL drain_keys_tried: got %0d expected 45", ifa.keys_tried); end
  endtask

  task automatic test_simultaneous_match();
    int m, f;
    lat_a[0] = 10; lat_a[1] = 10; lat_a[2] = 10; lat_a[3] = 8;
    tgt_a0 = 22'd5; tgt_a1 = 22'd7; tgt_a_en = 1'b1;
    m = -1; f = -1;
    pulse_start_a();
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (m < 0 && (ifa.core_done & ifa.core_match) != 4'b0) begin
        m = k;
        checks++;
        if ((ifa.core_done & ifa.core_match) !== 4'b1010 || ifa.keys_tried !== 23'd7) begin
          failures++; $display("FAIL simul_entry: got match=%b tried=%0d expected 1010 7", ifa.core_done & ifa.core_match, ifa.keys_tried);
        end
      end
      if (ifa.found) begin f = k; break; end
    end
    checks++; if (m != 25 || f != 26) begin failures++; $display("FAIL simul_timing: got match=%0d found=%0d expected 25 26", m, f); end
    checks++; if (ifa.found_key !== 22'd5) begin failures++; $display("FAIL simul_found_key: got %0d expected 5", ifa.found_key); end
    checks++; if (ifa.keys_tried !== 23'd8) begin failures++; $display("FAIL simul_keys_tried: got %0d expected 8", ifa.keys_tried); end
  endtask

  task automatic test_exhaust();
    int n_disp, bad, exp_next;
    for (int i = 0; i < NC; i++) lat_b[i] = 3;
    tgt_b_en = 1'b0;
    n_disp = 0; bad = 0; exp_next = 0;
    pulse_start_b();
    for (int k = 1; k <= 200; k++) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        if (ifb.core_start[i]) begin
          n_disp++;
          if (int'(ifb.core_key[i*KWB +: KWB]) != exp_next) bad++;
          exp_next++;
        end
      end
      if (ifb.exhausted && k > 40) break;
    end
    checks++; if (ifb.exhausted !== 1'b1) begin failures++; $display("FAIL exhaust_flag: got %0d expected 1", ifb.exhausted); end
    checks++; if (n_disp != 16) begin failures++; $display("FAIL exhaust_dispatches: got %0d expected 16", n_disp); end
    checks++; if (bad != 0) begin failures++; $display("FAIL exhaust_key_order: got %0d out-of-order keys expected 0", bad); end
    checks++; if (ifb.keys_tried !== 5'd16) begin failures++; $display("FAIL exhaust_keys_tried: got %0d expected 16", ifb.keys_tried); end
    checks++; if (ifb.found !== 1'b0 || ifb.busy !== 1'b0) begin failures++; $display("FAIL exhaust_flags: got found=%0d busy=%0d expected 0 0", ifb.found, ifb.busy); end
  endtask

  task automatic test_match_last();
    bit saw_exh;
    for (int i = 0; i < NC; i++) lat_b[i] = 3;
    tgt_b = 4'd15; tgt_b_en = 1'b1;
    saw_exh = 1'b0;
    pulse_start_b();
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (ifb.exhausted) saw_exh = 1'b1;
      if (ifb.found) break;
    end
    checks++; if (ifb.found !== 1'b1) begin failures++; $display("FAIL last_found: got %0d expected 1", ifb.found); end
    checks++; if (ifb.found_key !== 4'd15) begin failures++; $display("FAIL last_found_key: got %0d expected 15", ifb.found_key); end
    checks++; if (saw_exh || ifb.exhausted !== 1'b0) begin failures++; $display("FAIL last_exhausted: got %0d expected 0", saw_exh | ifb.exhausted); end
    checks++; if (ifb.keys_tried !== 5'd16) begin failures++; $display("FAIL last_keys_tried: got %0d expected 16", ifb.keys_tried); end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    tgt_a_en  = 1'b0;
    tgt_b_en  = 1'b0;
    tgt_a0    = '0;
    tgt_a1    = '0;
    tgt_b     = '0;
    for (int i = 0; i < NC; i++) begin
      lat_a[i] = 10;
      lat_b[i] = 3;
    end
    reset_n = 1'b0;
    test_reset();
    test_dispatch_order();
    test_reset_mid();
    test_match_drain();
    test_simultaneous_match();
    test_exhaust();
    test_match_last();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
